// File: rtl/exerion_pkg.sv
// ---------------------------------------------------------------------------
// exerion_pkg -- shared definitions for the Exerion ROM loader.
//
// Holds the ROM region map (byte base / byte size of every region), the
// region-index enum used to pick a bit of the one-hot chip select, the loader
// state enum and the hps_io slot index that carries the DIP switch bytes.
// ---------------------------------------------------------------------------
package exerion_pkg;

    localparam logic [24:0] MAIN_BASE = 25'h00000;
    localparam logic [24:0] MAIN_SIZE = 25'h06000;
    localparam logic [24:0] SUB_BASE  = 25'h06000;
    localparam logic [24:0] SUB_SIZE  = 25'h02000;
    localparam logic [24:0] CHAR_BASE = 25'h08000;
    localparam logic [24:0] CHAR_SIZE = 25'h02000;
    localparam logic [24:0] SPR_BASE  = 25'h0A000;
    localparam logic [24:0] SPR_SIZE  = 25'h04000;
    localparam logic [24:0] BG_BASE   = 25'h0E000;
    localparam logic [24:0] BG_SIZE   = 25'h08000;
    localparam logic [24:0] PROM_BASE = 25'h16000;
    localparam logic [24:0] PROM_SIZE = 25'h00400;

    // Bit position of each region inside the one-hot rom_cs vector.
    typedef enum logic [2:0] {
        REG_MAIN = 3'd0,
        REG_SUB  = 3'd1,
        REG_CHAR = 3'd2,
        REG_SPR  = 3'd3,
        REG_BG   = 3'd4,
        REG_PROM = 3'd5
    } region_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_HOLD  = 3'd3,
        ST_RUN   = 3'd4
    } loader_state_e;

    localparam logic [7:0] DIP_INDEX = 8'd254;

    // First byte address past a region.
    function automatic logic [24:0] region_end(input logic [24:0] base,
                                               input logic [24:0] size);
        return base + size;
    endfunction

endpackage

// File: rtl/rom_region_decode.sv
// ---------------------------------------------------------------------------
// rom_region_decode -- purely combinational ROM region decoder.
//
// Ports:
//   addr_i  [24:0]  hps_io byte address
//   cs_o    [5:0]   one-hot region select (all zero when out of range)
//   rel_o   [15:0]  address relative to the region base, truncated to 16 bits
//   valid_o         address falls inside one of the regions
// ---------------------------------------------------------------------------
module rom_region_decode
    import exerion_pkg::*;
(
    input  logic [24:0] addr_i,
    output logic [5:0]  cs_o,
    output logic [15:0] rel_o,
    output logic        valid_o
);

    // Regions are contiguous and ascending from 0, so only upper bounds
    // need comparing.
    always_comb begin
        cs_o    = '0;
        rel_o   = '0;
        valid_o = 1'b0;
        if (addr_i < region_end(MAIN_BASE, MAIN_SIZE)) begin
            cs_o[REG_MAIN] = 1'b1;
            rel_o          = 16'(addr_i - MAIN_BASE);
            valid_o        = 1'b1;
        end else if (addr_i < region_end(SUB_BASE, SUB_SIZE)) begin
            cs_o[REG_SUB] = 1'b1;
            rel_o         = 16'(addr_i - SUB_BASE);
            valid_o       = 1'b1;
        end else if (addr_i < region_end(CHAR_BASE, CHAR_SIZE)) begin
            cs_o[REG_CHAR] = 1'b1;
            rel_o          = 16'(addr_i - CHAR_BASE);
            valid_o        = 1'b1;
        end else if (addr_i < region_end(SPR_BASE, SPR_SIZE)) begin
            cs_o[REG_SPR] = 1'b1;
            rel_o         = 16'(addr_i - SPR_BASE);
            valid_o       = 1'b1;
        end else if (addr_i < region_end(BG_BASE, BG_SIZE)) begin
            cs_o[REG_BG] = 1'b1;
            rel_o        = 16'(addr_i - BG_BASE);
            valid_o      = 1'b1;
        end else if (addr_i < region_end(PROM_BASE, PROM_SIZE)) begin
            cs_o[REG_PROM] = 1'b1;
            rel_o          = 16'(addr_i - PROM_BASE);
            valid_o        = 1'b1;
        end
    end

endmodule

// File: rtl/rom_loader.sv
// ---------------------------------------------------------------------------
// rom_loader -- routes the hps_io ROM download into the Exerion ROM regions
// and sequences the core reset around the load.
//
// Ports:
//   clkm_20MHZ            single clock, rising edge
//   RESET_n               asynchronous active-low reset
//   ioctl_download/index/wr/addr/dout   hps_io download bus
//   ioctl_wait            back-pressure to hps_io (= byte pending)
//   mem_busy              target memory cannot accept a write this cycle
//   rom_cs/addr/data/we   region write port (one-hot cs, relative address)
//   core_reset_n          core reset, released only in RUN
//   load_done             high in RUN
//   addr_err              sticky: an accepted byte hit no region
//   dip1, dip2            DIP bytes (only with EXERION_DIP_CAPTURE_EN)
//   state_dbg             current loader state
//
// Handshake: a byte is taken when ioctl_wr=1 for our slot while the one-deep
// buffer is empty; ioctl_wait mirrors the buffer flag, and a strobe arriving
// while it is high is discarded. The buffered byte leaves as a single rom_we
// cycle in the first cycle where mem_busy=0.
//
// Build option: define EXERION_DIP_CAPTURE_EN to add dip1/dip2 capture from
// hps_io slot 254.
// ---------------------------------------------------------------------------
module rom_loader
    import exerion_pkg::*;
#(
    parameter logic [7:0] ROM_INDEX = 8'd0,
    parameter int         RST_HOLD  = 16
) (
    input  logic          clkm_20MHZ,
    input  logic          RESET_n,
    input  logic          ioctl_download,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic          ioctl_wait,
    input  logic          mem_busy,
    output logic [5:0]    rom_cs,
    output logic [15:0]   rom_addr,
    output logic [7:0]    rom_data,
    output logic          rom_we,
    output logic          core_reset_n,
    output logic          load_done,
    output logic          addr_err,
`ifdef EXERION_DIP_CAPTURE_EN
    output logic [7:0]    dip1,
    output logic [7:0]    dip2,
`endif
    output loader_state_e state_dbg
);

    logic [5:0]    dec_cs;
    logic [15:0]   dec_rel;
    logic          dec_valid;

    loader_state_e state_q;
    logic          pend_q, pend_d;
    logic          pend_valid_q;
    logic [5:0]    cs_q;
    logic [15:0]   addr_q;
    logic [7:0]    data_q;
    logic [15:0]   hold_cnt_q;
    logic          core_reset_n_q;
    logic          load_done_q;
    logic          addr_err_q;

    logic          rom_match;
    logic          accept;
    logic          issue;
    logic          retire;
    logic          enter_load;

    rom_region_decode u_decode (
        .addr_i  (ioctl_addr),
        .cs_o    (dec_cs),
        .rel_o   (dec_rel),
        .valid_o (dec_valid)
    );

    assign rom_match = (ioctl_index == ROM_INDEX);
    assign accept    = ioctl_wr && rom_match && ioctl_download && !pend_q;
    // Write strobe is combinational on mem_busy so the byte goes out in the
    // cycle right after the strobe when memory is free.
    assign issue     = pend_q && pend_valid_q && !mem_busy;
    // Out-of-range bytes retire without a write on their first pending cycle.
    assign retire    = issue || (pend_q && !pend_valid_q);
    assign pend_d    = accept || (pend_q && !retire);
    assign enter_load = ioctl_download && rom_match &&
                        ((state_q == ST_IDLE) || (state_q == ST_RUN));

    always_ff @(posedge clkm_20MHZ or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q        <= ST_IDLE;
            pend_q         <= 1'b0;
            pend_valid_q   <= 1'b0;
            cs_q           <= '0;
            addr_q         <= '0;
            data_q         <= '0;
            hold_cnt_q     <= '0;
            core_reset_n_q <= 1'b0;
            load_done_q    <= 1'b0;
            addr_err_q     <= 1'b0;
        end else begin
            pend_q <= pend_d;
            if (accept) begin
                cs_q         <= dec_cs;
                addr_q       <= dec_rel;
                data_q       <= ioctl_dout;
                pend_valid_q <= dec_valid;
            end

            // A bad byte in the same cycle as a load start still flags.
            addr_err_q <= (addr_err_q && !enter_load) || (accept && !dec_valid);

            case (state_q)
                ST_IDLE: begin
                    if (enter_load) state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (!ioctl_download) state_q <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    // Leave as the last byte drains so the hold count
                    // starts on the edge the buffer empties.
                    if (!pend_d) begin
                        state_q    <= ST_HOLD;
                        hold_cnt_q <= '0;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt_q == 16'(RST_HOLD - 1)) begin
                        state_q        <= ST_RUN;
                        core_reset_n_q <= 1'b1;
                        load_done_q    <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 16'd1;
                    end
                end
                ST_RUN: begin
                    if (enter_load) begin
                        state_q        <= ST_LOAD;
                        core_reset_n_q <= 1'b0;
                        load_done_q    <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ioctl_wait   = pend_q;
    assign rom_we       = issue;
    assign rom_cs       = cs_q;
    assign rom_addr     = addr_q;
    assign rom_data     = data_q;
    assign core_reset_n = core_reset_n_q;
    assign load_done    = load_done_q;
    assign addr_err     = addr_err_q;
    assign state_dbg    = state_q;

`ifdef EXERION_DIP_CAPTURE_EN
    // Only bytes 1 and 2 of the DIP slot reach the core; other offsets are
    // accepted by hps_io but have no storage here.
    logic [7:0] dip1_q, dip2_q;
    logic       dip_wr;

    assign dip_wr = ioctl_wr && (ioctl_index == DIP_INDEX) &&
                    (ioctl_addr[24:3] == 22'd0);

    always_ff @(posedge clkm_20MHZ or negedge RESET_n) begin
        if (!RESET_n) begin
            dip1_q <= 8'h00;
            dip2_q <= 8'h00;
        end else if (dip_wr) begin
            case (ioctl_addr[2:0])
                3'd1:    dip1_q <= ioctl_dout;
                3'd2:    dip2_q <= ioctl_dout;
                default: ;
            endcase
        end
    end

    assign dip1 = dip1_q & 8'h7F;
    assign dip2 = dip2_q;
`endif

endmodule

// File: tb/tb_rom_loader.sv
module tb_rom_loader;
    import exerion_pkg::*;

    localparam int RST_HOLD = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          dl;
    logic [7:0]    idx;
    logic          wr;
    logic [24:0]   addr;
    logic [7:0]    dout;
    logic          busy;
    logic          ioctl_wait;
    logic [5:0]    rom_cs;
    logic [15:0]   rom_addr;
    logic [7:0]    rom_data;
    logic          rom_we;
    logic          core_reset_n;
    logic          load_done;
    logic          addr_err;
    loader_state_e state_dbg;
`ifdef EXERION_DIP_CAPTURE_EN
    logic [7:0]    dip1;
    logic [7:0]    dip2;
`endif

    rom_loader #(.ROM_INDEX(8'd0), .RST_HOLD(RST_HOLD)) dut (
        .clkm_20MHZ     (clk),
        .RESET_n        (rst_n),
        .ioctl_download (dl),
        .ioctl_index    (idx),
        .ioctl_wr       (wr),
        .ioctl_addr     (addr),
        .ioctl_dout     (dout),
        .ioctl_wait     (ioctl_wait),
        .mem_busy       (busy),
        .rom_cs         (rom_cs),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .rom_we         (rom_we),
        .core_reset_n   (core_reset_n),
        .load_done      (load_done),
        .addr_err       (addr_err),
`ifdef EXERION_DIP_CAPTURE_EN
        .dip1           (dip1),
        .dip2           (dip2),
`endif
        .state_dbg      (state_dbg)
    );

    // ---------------- checking ----------------
    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Returns 2 time units after the rising edge; callers change inputs,
    // then wait #1 before sampling.
    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic rom_write(input logic [24:0] a, input logic [7:0] d,
                             input logic [5:0] exp_cs, input logic [15:0] exp_ra);
        wr   = 1'b1;
        addr = a;
        dout = d;
        busy = 1'b0;
        cycle();
        wr = 1'b0;
        #1;
        check_eq($sformatf("we@%0h", a),   32'(rom_we),     32'd1);
        check_eq($sformatf("cs@%0h", a),   32'(rom_cs),     32'(exp_cs));
        check_eq($sformatf("ra@%0h", a),   32'(rom_addr),   32'(exp_ra));
        check_eq($sformatf("data@%0h", a), 32'(rom_data),   32'(d));
        check_eq($sformatf("wait@%0h", a), 32'(ioctl_wait), 32'd1);
        cycle();
        #1;
        check_eq($sformatf("we_off@%0h", a),   32'(rom_we),     32'd0);
        check_eq($sformatf("wait_off@%0h", a), 32'(ioctl_wait), 32'd0);
    endtask

    typedef struct {
        logic [24:0] a;
        logic [7:0]  d;
        logic [5:0]  cs;
        logic [15:0] ra;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{25'h05FFF, 8'h11, 6'b000001, 16'h5FFF};
        vecs[1] = '{25'h08000, 8'h22, 6'b000100, 16'h0000};
        vecs[2] = '{25'h09FFF, 8'h33, 6'b000100, 16'h1FFF};
        vecs[3] = '{25'h0E000, 8'h44, 6'b010000, 16'h0000};
        vecs[4] = '{25'h15FFF, 8'h55, 6'b010000, 16'h7FFF};
        vecs[5] = '{25'h163FF, 8'h66, 6'b100000, 16'h03FF};

        rst_n = 1'b0;
        dl    = 1'b0;
        idx   = 8'd0;
        wr    = 1'b0;
        addr  = '0;
        dout  = '0;
        busy  = 1'b0;
        repeat (2) cycle();
        #1;
        check_eq("rst_we",    32'(rom_we),       32'd0);
        check_eq("rst_cs",    32'(rom_cs),       32'd0);
        check_eq("rst_addr",  32'(rom_addr),     32'd0);
        check_eq("rst_data",  32'(rom_data),     32'd0);
        check_eq("rst_wait",  32'(ioctl_wait),   32'd0);
        check_eq("rst_core",  32'(core_reset_n), 32'd0);
        check_eq("rst_done",  32'(load_done),    32'd0);
        check_eq("rst_err",   32'(addr_err),     32'd0);
        check_eq("rst_state", 32'(state_dbg),    32'(ST_IDLE));
`ifdef EXERION_DIP_CAPTURE_EN
        check_eq("rst_dip1",  32'(dip1),         32'd0);
        check_eq("rst_dip2",  32'(dip2),         32'd0);
`endif
        rst_n = 1'b1;
        cycle();

        // Start a ROM download.
        dl  = 1'b1;
        idx = 8'd0;
        cycle();
        #1;
        check_eq("state_load", 32'(state_dbg), 32'(ST_LOAD));

        // Sub CPU byte, free memory: written the very next cycle.
        rom_write(25'h06010, 8'hA5, 6'b000010, 16'h0010);

        // Region boundaries.
        foreach (vecs[i]) rom_write(vecs[i].a, vecs[i].d, vecs[i].cs, vecs[i].ra);

        // Sprite byte with memory busy for 3 cycles; a strobe during the
        // wait must be discarded.
        wr   = 1'b1;
        addr = 25'h0A000;
        dout = 8'h5A;
        busy = 1'b1;
        cycle();
        wr = 1'b0;
        #1;
        check_eq("busy1_wait", 32'(ioctl_wait), 32'd1);
        check_eq("busy1_we",   32'(rom_we),     32'd0);
        cycle();
        wr   = 1'b1;
        addr = 25'h08000;
        dout = 8'h11;
        #1;
        check_eq("busy2_wait", 32'(ioctl_wait), 32'd1);
        check_eq("busy2_we",   32'(rom_we),     32'd0);
        cycle();
        wr = 1'b0;
        #1;
        check_eq("busy3_wait", 32'(ioctl_wait), 32'd1);
        check_eq("busy3_we",   32'(rom_we),     32'd0);
        cycle();
        busy = 1'b0;
        #1;
        check_eq("free_wait", 32'(ioctl_wait), 32'd1);
        check_eq("free_we",   32'(rom_we),     32'd1);
        check_eq("free_cs",   32'(rom_cs),     32'b001000);
        check_eq("free_ra",   32'(rom_addr),   32'h0000);
        check_eq("free_data", 32'(rom_data),   32'h5A);
        cycle();
        #1;
        check_eq("after_wait", 32'(ioctl_wait), 32'd0);
        check_eq("after_we",   32'(rom_we),     32'd0);
        check_eq("after_data", 32'(rom_data),   32'h5A);
        cycle();
        #1;
        check_eq("dropped_we", 32'(rom_we), 32'd0);

        // Out-of-range byte just past PROM.
        wr   = 1'b1;
        addr = 25'h16400;
        dout = 8'h99;
        cycle();
        wr = 1'b0;
        #1;
        check_eq("oor_we",   32'(rom_we),     32'd0);
        check_eq("oor_cs",   32'(rom_cs),     32'd0);
        check_eq("oor_err",  32'(addr_err),   32'd1);
        check_eq("oor_wait", 32'(ioctl_wait), 32'd1);
        cycle();
        #1;
        check_eq("oor_wait_clr", 32'(ioctl_wait), 32'd0);
        check_eq("oor_err_hold", 32'(addr_err),   32'd1);
        check_eq("oor_we_clr",   32'(rom_we),     32'd0);

        // Last byte held by busy memory while the download ends.
        wr   = 1'b1;
        addr = 25'h00100;
        dout = 8'h77;
        busy = 1'b1;
        cycle();
        wr = 1'b0;
        dl = 1'b0;
        #1;
        check_eq("last_wait", 32'(ioctl_wait), 32'd1);
        cycle();
        #1;
        check_eq("state_flush", 32'(state_dbg), 32'(ST_FLUSH));
        check_eq("flush_we",    32'(rom_we),    32'd0);
        cycle();
        busy = 1'b0;
        #1;
        check_eq("last_we", 32'(rom_we),   32'd1);
        check_eq("last_cs", 32'(rom_cs),   32'b000001);
        check_eq("last_ra", 32'(rom_addr), 32'h0100);
        for (int n = 1; n <= RST_HOLD + 1; n++) begin
            cycle();
            #1;
            if (n == 1) check_eq("state_hold", 32'(state_dbg), 32'(ST_HOLD));
            if (n >= RST_HOLD)
                check_eq($sformatf("core_rst_n@%0d", n), 32'(core_reset_n),
                         (n == RST_HOLD + 1) ? 32'd1 : 32'd0);
        end
        check_eq("run_state", 32'(state_dbg), 32'(ST_RUN));
        check_eq("run_done",  32'(load_done), 32'd1);
        check_eq("run_err",   32'(addr_err),  32'd1);

        // A foreign-slot download must not touch the loader.
        dl   = 1'b1;
        idx  = 8'd5;
        wr   = 1'b1;
        addr = 25'h06000;
        dout = 8'hEE;
        cycle();
        #1;
        check_eq("foreign_we",   32'(rom_we),     32'd0);
        check_eq("foreign_wait", 32'(ioctl_wait), 32'd0);
        cycle();
        wr = 1'b0;
        #1;
        check_eq("foreign_state", 32'(state_dbg),    32'(ST_RUN));
        check_eq("foreign_core",  32'(core_reset_n), 32'd1);
        check_eq("foreign_cs",    32'(rom_cs),       32'b000001);
        check_eq("foreign_ra",    32'(rom_addr),     32'h0100);
        check_eq("foreign_data",  32'(rom_data),     32'h77);
        dl  = 1'b0;
        idx = 8'd0;
        cycle();

        // New ROM download from RUN clears the error flag.
        dl = 1'b1;
        cycle();
        #1;
        check_eq("reload_state", 32'(state_dbg),    32'(ST_LOAD));
        check_eq("reload_err",   32'(addr_err),     32'd0);
        check_eq("reload_core",  32'(core_reset_n), 32'd0);
        check_eq("reload_done",  32'(load_done),    32'd0);

        // Reset mid-load with a byte pending.
        wr   = 1'b1;
        addr = 25'h0A010;
        dout = 8'hC3;
        busy = 1'b1;
        cycle();
        wr = 1'b0;
        #1;
        check_eq("pre_rst_wait", 32'(ioctl_wait), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_state", 32'(state_dbg),    32'(ST_IDLE));
        check_eq("mid_rst_wait",  32'(ioctl_wait),   32'd0);
        check_eq("mid_rst_we",    32'(rom_we),       32'd0);
        check_eq("mid_rst_cs",    32'(rom_cs),       32'd0);
        check_eq("mid_rst_addr",  32'(rom_addr),     32'd0);
        check_eq("mid_rst_data",  32'(rom_data),     32'd0);
        check_eq("mid_rst_core",  32'(core_reset_n), 32'd0);
        check_eq("mid_rst_done",  32'(load_done),    32'd0);
        check_eq("mid_rst_err",   32'(addr_err),     32'd0);
        cycle();
        rst_n = 1'b1;
        dl    = 1'b0;
        busy  = 1'b0;
        cycle();
        cycle();
        #1;
        check_eq("post_rst_state", 32'(state_dbg),    32'(ST_IDLE));
        check_eq("post_rst_we",    32'(rom_we),       32'd0);
        check_eq("post_rst_wait",  32'(ioctl_wait),   32'd0);
        check_eq("post_rst_core",  32'(core_reset_n), 32'd0);

`ifdef EXERION_DIP_CAPTURE_EN
        dl   = 1'b1;
        idx  = DIP_INDEX;
        wr   = 1'b1;
        addr = 25'h1;
        dout = 8'hFF;
        cycle();
        #1;
        check_eq("dip_we1", 32'(rom_we), 32'd0);
        addr = 25'h2;
        dout = 8'h3C;
        cycle();
        #1;
        check_eq("dip_we2", 32'(rom_we), 32'd0);
        addr = 25'h9;
        dout = 8'h01;
        cycle();
        wr = 1'b0;
        dl = 1'b0;
        #1;
        check_eq("dip1",      32'(dip1),      32'h7F);
        check_eq("dip2",      32'(dip2),      32'h3C);
        check_eq("dip_state", 32'(state_dbg), 32'(ST_IDLE));
        check_eq("dip_wait",  32'(ioctl_wait), 32'd0);
        idx = 8'd0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
